jpeg_dequantizer: RTL and testbench

//  Decoder-side inverse of the encoder quantizer. Takes 8-bit signed quantized coefficients,
//  64 per block in zigzag order, multiplies each by its entry in a loadable 64-entry

---
 rtl/jpeg_pkg.sv | 15 +
 rtl/jpeg_dequantizer_if.sv | 24 ++
 rtl/jpeg_qtable_ram.sv | 23 ++
 rtl/jpeg_dequantizer.sv | 58 +++++
 tb/tb_jpeg_dequantizer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared widths, limits, FSM state encoding and product saturation for the dequantizer
package jpeg_pkg;
  localparam int COEF_PER_BLOCK = 64;
  localparam int IDX_W = 6;
  localparam int QIN_W = 8;
  localparam int QV_W = 8;
  localparam int DCT_W = 12;
  localparam int PROD_W = QIN_W + QV_W + 1;
  localparam int DCT_MAX = 2047;
  localparam int DCT_MIN = -2048;
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  function automatic logic [DCT_W-1:0] sat(input logic signed [PROD_W-1:0] p);
    return p > PROD_W'(DCT_MAX) ? DCT_W'(DCT_MAX) : p < PROD_W'(DCT_MIN) ? DCT_W'(DCT_MIN) : p[DCT_W-1:0];
  endfunction
endpackage

// File: rtl/jpeg_dequantizer_if.sv
// jpeg_dequantizer_if: table-load (tbl_we/addr/data/ready), coefficient-in (in_valid/ready/coef) and coefficient-out (out_valid/ready/coef/idx/last) handshakes
interface jpeg_dequantizer_if;
  import jpeg_pkg::*;
  logic tbl_we;
  logic tbl_ready;
  logic [IDX_W-1:0] tbl_addr;
  logic [QV_W-1:0] tbl_data;
  logic in_valid;
  logic in_ready;
  logic [QIN_W-1:0] in_coef;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic [DCT_W-1:0] out_coef;
  logic [IDX_W-1:0] out_idx;
  modport master(
    output tbl_we, tbl_addr, tbl_data, in_valid, in_coef, out_ready,
    input tbl_ready, in_ready, out_valid, out_coef, out_idx, out_last
  );
  modport slave(
    input tbl_we, tbl_addr, tbl_data, in_valid, in_coef, out_ready,
    output tbl_ready, in_ready, out_valid, out_coef, out_idx, out_last
  );
endinterface

// File: rtl/jpeg_qtable_ram.sv
// jpeg_qtable_ram: 64-entry quantization table, sync write (we/waddr/wdata), registered read (re/raddr/rdata), resets to all 1
module jpeg_qtable_ram
  import jpeg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [QV_W-1:0]  wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [QV_W-1:0]  rdata
);
  logic [QV_W-1:0] mem [COEF_PER_BLOCK];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < COEF_PER_BLOCK; i++) mem[i] <= QV_W'(1);
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/jpeg_dequantizer.sv
// jpeg_dequantizer: 2-stage coefficient * table-entry multiply with saturation to 12 bits; clk, rst, bus (slave: table load, coef in, coef out)
module jpeg_dequantizer
  import jpeg_pkg::*;
(
  input logic clk,
  input logic rst,
  jpeg_dequantizer_if.slave bus
);
  state_t state;
  logic [IDX_W-1:0] cnt, idx1;
  logic [QIN_W-1:0] coef1;
  logic [QV_W-1:0] q, ent;
  logic v1, pipe_en, idle, wr, acc;
  logic signed [PROD_W-1:0] prod;
  assign idle = state == ST_IDLE;
  assign pipe_en = ~bus.out_valid | bus.out_ready;
  assign wr = idle & bus.tbl_we;
  assign acc = bus.in_valid & bus.in_ready;
  assign bus.tbl_ready = idle;
  assign bus.in_ready = pipe_en & ~wr;
  assign ent = q == '0 ? QV_W'(1) : q;
  assign prod = PROD_W'($signed(coef1)) * PROD_W'($signed({1'b0, ent}));
  jpeg_qtable_ram ram (
    .clk(clk),
    .rst(rst),
    .we(wr),
    .waddr(bus.tbl_addr),
    .wdata(bus.tbl_data),
    .re(pipe_en),
    .raddr(cnt),
    .rdata(q)
  );
  // Idle only once the last coefficient leaves with nothing behind it; stalls freeze every stage, so ~v1 means empty.
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      v1 <= 1'b0;
      coef1 <= '0;
      idx1 <= '0;
      bus.out_valid <= 1'b0;
      bus.out_coef <= '0;
      bus.out_idx <= '0;
      bus.out_last <= 1'b0;
    end else begin
      if (acc) cnt <= cnt + IDX_W'(1);
      if (pipe_en) begin
        v1 <= acc;
        coef1 <= bus.in_coef;
        idx1 <= cnt;
        bus.out_valid <= v1;
        bus.out_coef <= sat(prod);
        bus.out_idx <= idx1;
        bus.out_last <= idx1 == IDX_W'(COEF_PER_BLOCK - 1);
      end
      state <= acc ? ST_ACTIVE : (bus.out_valid & bus.out_ready & bus.out_last & ~v1) ? ST_IDLE : state;
    end
endmodule

// File: tb/tb_jpeg_dequantizer.sv
// tb_jpeg_dequantizer: vector table plus scoreboard bench for jpeg_dequantizer
module tb_jpeg_dequantizer;
  import jpeg_pkg::*;
  typedef struct {int addr; int val; int coef; int exp;} vec_t;
  typedef struct {int coef; int idx;} sb_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  jpeg_dequantizer_if bus();
  jpeg_dequantizer dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int pass_n = 0;
  int total = 0;
  sb_t sb[$];
  logic [QV_W-1:0] tm [COEF_PER_BLOCK];
  int mcnt = 0;
  int probe = -1;
  int cap = 0;
  int nlast = 0;
  int prev_out = 0;
  bit rand_mode = 0;
  bit rec = 0;
  bit which = 0;
  bit busy_chk = 0;
  bit want_first = 0;
  bit prev_stall = 0;
  int log_a[$];
  int log_b[$];
  vec_t vecs[11];
  logic [QIN_W-1:0] rb [192];
  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act == req) pass_n++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, req);
  endtask
  function automatic int mexp(input logic [QIN_W-1:0] c, input logic [QV_W-1:0] t);
    int p;
    p = int'($signed(c)) * (t == 0 ? 1 : int'(t));
    return p > 2047 ? 2047 : p < -2048 ? -2048 : p;
  endfunction
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin : mon
    int oc;
    int oi;
    sb_t e;
    if (rst) begin
      sb.delete();
      mcnt = 0;
      prev_stall = 0;
      for (int i = 0; i < COEF_PER_BLOCK; i++) tm[i] = 8'd1;
    end else begin
      if (prev_stall) chk("stall_hold", int'({bus.out_valid, bus.out_coef, bus.out_idx, bus.out_last}), prev_out);
      if (bus.tbl_we && busy_chk) chk("tbl_ready_busy", int'(bus.tbl_ready), 0);
      if (bus.tbl_we && bus.tbl_ready) tm[bus.tbl_addr] = bus.tbl_data;
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back('{mexp(bus.in_coef, tm[mcnt]), mcnt});
        mcnt = (mcnt + 1) % COEF_PER_BLOCK;
      end
      if (bus.out_valid && bus.out_ready) begin
        oc = int'($signed(bus.out_coef));
        oi = int'(bus.out_idx);
        if (sb.size() == 0) chk("unexpected_output", oi, -1);
        else begin
          e = sb.pop_front();
          chk("coef", oc, e.coef);
          chk("idx", oi, e.idx);
          chk("last", int'(bus.out_last), int'(e.idx == 63));
        end
        if (oi == probe) cap = oc;
        if (bus.out_last) nlast++;
        if (want_first) begin
          chk("first_idx_after_rst", oi, 0);
          want_first = 0;
        end
        if (rec && !which) log_a.push_back(oc * 64 + oi);
        if (rec && which) log_b.push_back(oc * 64 + oi);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out = int'({bus.out_valid, bus.out_coef, bus.out_idx, bus.out_last});
    end
  end
  task automatic send(input logic [QIN_W-1:0] c);
    int n;
    logic ok;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_coef = c;
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", n, 0);
    bus.in_valid = 1'b0;
  endtask
  task automatic send_blk(input int p, input int pc);
    for (int k = 0; k < COEF_PER_BLOCK; k++) send(k == p ? 8'(pc) : 8'($urandom));
  endtask
  task automatic wr(input int a, input int d);
    bus.tbl_we = 1'b1;
    bus.tbl_addr = 6'(a);
    bus.tbl_data = 8'(d);
    @(negedge clk);
    chk("tbl_ready_idle", int'(bus.tbl_ready), 1);
    @(posedge clk);
    #1;
    bus.tbl_we = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || bus.out_valid) && n < 1000);
    if (n >= 1000) chk("drain_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int mism;
    int m;
    vecs[0] = '{3, 16, 5, 80};
    vecs[1] = '{4, 16, -3, -48};
    vecs[2] = '{5, 16, 127, 2032};
    vecs[3] = '{6, 16, -128, -2048};
    vecs[4] = '{0, 255, 127, 2047};
    vecs[5] = '{0, 255, -128, -2048};
    vecs[6] = '{0, 0, 7, 7};
    vecs[7] = '{0, 0, -128, -128};
    vecs[8] = '{63, 2, -100, -200};
    vecs[9] = '{10, 200, -10, -2000};
    vecs[10] = '{10, 200, 11, 2047};
    bus.tbl_we = 1'b0;
    bus.tbl_addr = '0;
    bus.tbl_data = '0;
    bus.in_valid = 1'b0;
    bus.in_coef = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_coef", int'(bus.out_coef), 0);
    chk("rst_out_idx", int'(bus.out_idx), 0);
    chk("rst_out_last", int'(bus.out_last), 0);
    chk("rst_tbl_ready", int'(bus.tbl_ready), 1);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    nlast = 0;
    for (int k = 0; k < COEF_PER_BLOCK; k++) send(8'(k - 32));
    drain();
    chk("last_pulses", nlast, 1);
    for (int k = 0; k < COEF_PER_BLOCK; k++) wr(k, 16);
    for (int i = 0; i < 11; i++) begin
      wr(vecs[i].addr, vecs[i].val);
      probe = vecs[i].addr;
      cap = 9999;
      send_blk(vecs[i].addr, vecs[i].coef);
      drain();
      chk($sformatf("vec%0d", i), cap, vecs[i].exp);
    end
    wr(5, 3);
    probe = -1;
    for (int k = 0; k < COEF_PER_BLOCK; k++) begin
      if (k == 20) begin
        busy_chk = 1;
        bus.tbl_we = 1'b1;
        bus.tbl_addr = 6'd5;
        bus.tbl_data = 8'd99;
      end
      send(8'($urandom));
      if (k == 20) begin
        bus.tbl_we = 1'b0;
        busy_chk = 0;
      end
    end
    probe = 5;
    cap = 9999;
    send_blk(5, 10);
    drain();
    chk("old_table_kept", cap, 30);
    probe = -1;
    for (int i = 0; i < 192; i++) rb[i] = 8'($urandom);
    rec = 1;
    which = 0;
    for (int i = 0; i < 192; i++) send(rb[i]);
    drain();
    rand_mode = 1;
    which = 1;
    for (int i = 0; i < 192; i++) send(rb[i]);
    drain();
    rand_mode = 0;
    rec = 0;
    chk("ref_len", log_a.size(), 192);
    chk("rand_len", log_b.size(), 192);
    mism = 0;
    m = log_a.size() < log_b.size() ? log_a.size() : log_b.size();
    for (int i = 0; i < m; i++) if (log_a[i] != log_b[i]) mism++;
    chk("rand_vs_ref", mism, 0);
    for (int k = 0; k < 31; k++) send(8'($urandom));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_tbl_ready", int'(bus.tbl_ready), 1);
    @(posedge clk);
    #1;
    want_first = 1;
    probe = 1;
    cap = 9999;
    send_blk(1, 5);
    drain();
    chk("tbl_reset_identity", cap, 5);
    chk("first_idx_seen", int'(want_first), 0);
    $display("%0d/%0d checks passed", pass_n, total);
    $finish;
  end
endmodule
